// File: rtl/alu_pkg.sv
// Shared definitions for the compare-ALU arbiter: widths, opcodes, FSM states.
package alu_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned OPW   = 4;

  localparam logic [OPW-1:0] OP_TRA  = 4'd2;
  localparam logic [OPW-1:0] OP_INC  = 4'd3;
  localparam logic [OPW-1:0] OP_DEC  = 4'd4;
  localparam logic [OPW-1:0] OP_NOT  = 4'd5;
  localparam logic [OPW-1:0] OP_NOR  = 4'd6;
  localparam logic [OPW-1:0] OP_XOR  = 4'd7;
  localparam logic [OPW-1:0] OP_XNOR = 4'd8;
  localparam logic [OPW-1:0] OP_GT   = 4'd9;
  localparam logic [OPW-1:0] OP_LT   = 4'd10;
  localparam logic [OPW-1:0] OP_EQ   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_e;

  // Opcodes outside OP_TRA..OP_EQ have no defined ALU meaning.
  function automatic logic op_legal(input logic [OPW-1:0] ctrl);
    return (ctrl >= OP_TRA) && (ctrl <= OP_EQ);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant, one-hot output.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // A lone requester wins; on a tie the port that was not granted last wins.
  always_comb begin
    grant_o = valid_i;
    if (&valid_i) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: grants the shared compare ALU to one of two requesters,
// issues the operation for one cycle and returns the captured result.
module alu_arbiter #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned OPW   = alu_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_ctrl,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_s,
  output logic             resp0_err,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_s,
  output logic             resp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_s
);

  import alu_pkg::*;

  state_e           state_q, state_d;
  logic             last_q,  last_d;
  logic             port_q,  port_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [OPW-1:0]   ctrl_q,  ctrl_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             err_q,   err_d;
  logic [1:0]       grant;
  logic             resp_take;

  rr_arb2 u_arb (
    .valid_i ({req1_valid, req0_valid}),
    .last_i  (last_q),
    .grant_o (grant)
  );

  // Only the granted port's response handshake can complete the operation.
  assign resp_take = port_q ? resp1_ready : resp0_ready;

  // Next-state, operand latch and response capture.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    port_d     = port_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    res_d      = res_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // ready is masked during reset so nothing appears accepted.
        req0_ready = grant[0] & rst_n;
        req1_ready = grant[1] & rst_n;
        if (|grant) begin
          port_d  = grant[1];
          last_d  = grant[1];
          a_d     = grant[1] ? req1_a    : req0_a;
          b_d     = grant[1] ? req1_b    : req0_b;
          ctrl_d  = grant[1] ? req1_ctrl : req0_ctrl;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_legal(ctrl_q)) begin
          res_d = alu_s;
          err_d = 1'b0;
        end else begin
          res_d = '0;
          err_d = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_take) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response ports and ALU drive; the operand latch doubles as the ALU hold register.
  always_comb begin
    resp0_valid = (state_q == ST_RESP) && !port_q;
    resp1_valid = (state_q == ST_RESP) &&  port_q;
    resp0_s     = resp0_valid ? res_q : '0;
    resp1_s     = resp1_valid ? res_q : '0;
    resp0_err   = resp0_valid & err_q;
    resp1_err   = resp1_valid & err_q;
    alu_a       = a_q;
    alu_b       = b_q;
    alu_ctrl    = ctrl_q;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cycle table plus randomized run
// against a transaction-level reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned OW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OW-1:0] req0_ctrl = '0, req1_ctrl = '0;
  logic          resp0_valid, resp1_valid;
  logic          resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [W-1:0]  resp0_s, resp1_s;
  logic          resp0_err, resp1_err;
  logic [W-1:0]  alu_a, alu_b, alu_s;
  logic [OW-1:0] alu_ctrl;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .OPW(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_s(resp0_s), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_s(resp1_s), .resp1_err(resp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_s(alu_s)
  );

  // Behavioural compare ALU; illegal opcodes give a nonzero value so forcing to 0 is visible.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] c);
    case (c)
      OP_TRA:  return a;
      OP_INC:  return a + 8'd1;
      OP_DEC:  return a - 8'd1;
      OP_NOT:  return ~a;
      OP_NOR:  return ~(a | b);
      OP_XOR:  return a ^ b;
      OP_XNOR: return ~(a ^ b);
      OP_GT:   return ($signed(a) >  $signed(b)) ? 8'd1 : 8'd0;
      OP_LT:   return ($signed(a) <  $signed(b)) ? 8'd1 : 8'd0;
      OP_EQ:   return (a == b) ? 8'd1 : 8'd0;
      default: return a | 8'h81;
    endcase
  endfunction

  always_comb alu_s = ref_alu(alu_a, alu_b, alu_ctrl);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic v0, input logic v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [OW-1:0] c0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [OW-1:0] c1,
                       input logic rr0, input logic rr1);
    rst_n = rst; req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req0_ctrl = c0;
    req1_a = a1; req1_b = b1; req1_ctrl = c1;
    resp0_ready = rr0; resp1_ready = rr1;
  endtask

  typedef struct {
    logic rst, v0, v1;
    logic [W-1:0] a0, b0; logic [OW-1:0] c0;
    logic [W-1:0] a1, b1; logic [OW-1:0] c1;
    logic rr0, rr1;
    logic rdy0, rdy1, rv0, rv1;
    logic [W-1:0] s0, s1;
    logic e0, e1;
    logic [OW-1:0] ac;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic v0, input logic v1,
                     input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [OW-1:0] c0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [OW-1:0] c1,
                     input logic rr0, input logic rr1,
                     input logic rdy0, input logic rdy1, input logic rv0, input logic rv1,
                     input logic [W-1:0] s0, input logic [W-1:0] s1, input logic e0, input logic e1,
                     input logic [OW-1:0] ac);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.a0 = a0; v.b0 = b0; v.c0 = c0;
    v.a1 = a1; v.b1 = b1; v.c1 = c1; v.rr0 = rr0; v.rr1 = rr1;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.rv0 = rv0; v.rv1 = rv1;
    v.s0 = s0; v.s1 = s1; v.e0 = e0; v.e1 = e1; v.ac = ac;
    tbl.push_back(v);
  endtask

  // Reference model state: one outstanding transaction at most.
  bit           m_busy;
  int           m_age;
  int           m_owner;
  bit           m_last;
  logic [W-1:0] m_a, m_b;
  logic [OW-1:0] m_c;

  function automatic int winner(input logic v0, input logic v1, input bit last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_check();
    int  w;
    bit  rv0, rv1, legal;
    logic [W-1:0] res;
    w     = winner(req0_valid, req1_valid, m_last);
    rv0   = m_busy && m_age >= 2 && m_owner == 0;
    rv1   = m_busy && m_age >= 2 && m_owner == 1;
    legal = (m_c >= 4'd2) && (m_c <= 4'd11);
    res   = legal ? ref_alu(m_a, m_b, m_c) : 8'd0;
    chk("rnd rdy0", 32'(req0_ready), 32'(rst_n && !m_busy && w == 0));
    chk("rnd rdy1", 32'(req1_ready), 32'(rst_n && !m_busy && w == 1));
    chk("rnd rv0",  32'(resp0_valid), 32'(rv0));
    chk("rnd rv1",  32'(resp1_valid), 32'(rv1));
    chk("rnd s0",   32'(resp0_s), 32'(rv0 ? res : 8'd0));
    chk("rnd s1",   32'(resp1_s), 32'(rv1 ? res : 8'd0));
    chk("rnd e0",   32'(resp0_err), 32'(rv0 && !legal));
    chk("rnd e1",   32'(resp1_err), 32'(rv1 && !legal));
    chk("rnd alu_a",    32'(alu_a), 32'(m_a));
    chk("rnd alu_b",    32'(alu_b), 32'(m_b));
    chk("rnd alu_ctrl", 32'(alu_ctrl), 32'(m_c));
  endtask

  // Predict the effect of the coming clock edge from the inputs now applied.
  task automatic model_step();
    int w;
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_last = 1; m_a = '0; m_b = '0; m_c = '0;
    end else if (!m_busy) begin
      w = winner(req0_valid, req1_valid, m_last);
      if (w >= 0) begin
        m_busy = 1; m_age = 1; m_owner = w; m_last = (w == 1);
        m_a = w ? req1_a : req0_a;
        m_b = w ? req1_b : req0_b;
        m_c = w ? req1_ctrl : req0_ctrl;
      end
    end else if (m_age >= 2) begin
      if (m_owner == 0 ? resp0_ready : resp1_ready) m_busy = 0;
    end else begin
      m_age++;
    end
  endtask

  initial begin
    // Columns: rst v0 v1 a0 b0 c0 a1 b1 c1 rr0 rr1 | rdy0 rdy1 rv0 rv1 s0 s1 e0 e1 alu_ctrl
    // Reset with both requesting, then alternating grants with continuous requests.
    add(0,1,1, 5,0,7, 127,8'hFF,9, 1,1,  0,0,0,0, 0,0,0,0, 0);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  1,0,0,0, 0,0,0,0, 0);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  0,0,0,0, 0,0,0,0, 7);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  0,0,1,0, 5,0,0,0, 7);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  0,1,0,0, 0,0,0,0, 7);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  0,0,0,0, 0,0,0,0, 9);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  0,0,0,1, 0,1,0,0, 9);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  1,0,0,0, 0,0,0,0, 9);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  0,0,0,0, 0,0,0,0, 7);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  0,0,1,0, 5,0,0,0, 7);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  0,1,0,0, 0,0,0,0, 7);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  0,0,0,0, 0,0,0,0, 9);
    add(1,1,1, 5,0,7, 127,8'hFF,9, 1,1,  0,0,0,1, 0,1,0,0, 9);
    add(1,0,0, 5,0,7, 127,8'hFF,9, 1,1,  0,0,0,0, 0,0,0,0, 9);
    // Port 0 INC of 127 wraps to -128.
    add(1,1,0, 127,0,3, 0,0,0, 1,1,      1,0,0,0, 0,0,0,0, 9);
    add(1,0,0, 127,0,3, 0,0,0, 1,1,      0,0,0,0, 0,0,0,0, 3);
    add(1,0,0, 127,0,3, 0,0,0, 1,1,      0,0,1,0, 8'h80,0,0,0, 3);
    // Port 1 DEC of 0 held five cycles by resp1_ready low; port 0 waits, stray resp0_ready ignored.
    add(1,1,1, 9,3,13, 0,0,4, 0,0,       0,1,0,0, 0,0,0,0, 3);
    add(1,1,0, 9,3,13, 0,0,4, 0,0,       0,0,0,0, 0,0,0,0, 4);
    add(1,1,0, 9,3,13, 0,0,4, 0,0,       0,0,0,1, 0,8'hFF,0,0, 4);
    add(1,1,0, 9,3,13, 0,0,4, 1,0,       0,0,0,1, 0,8'hFF,0,0, 4);
    add(1,1,0, 9,3,13, 0,0,4, 0,0,       0,0,0,1, 0,8'hFF,0,0, 4);
    add(1,1,0, 9,3,13, 0,0,4, 0,0,       0,0,0,1, 0,8'hFF,0,0, 4);
    add(1,1,0, 9,3,13, 0,0,4, 0,0,       0,0,0,1, 0,8'hFF,0,0, 4);
    add(1,1,0, 9,3,13, 0,0,4, 0,1,       0,0,0,1, 0,8'hFF,0,0, 4);
    // Illegal opcode 13 then a legal TRA.
    add(1,1,0, 9,3,13, 0,0,0, 1,0,       1,0,0,0, 0,0,0,0, 4);
    add(1,0,0, 9,3,13, 0,0,0, 1,0,       0,0,0,0, 0,0,0,0, 13);
    add(1,0,0, 9,3,13, 0,0,0, 1,0,       0,0,1,0, 0,0,1,0, 13);
    add(1,1,0, 1,2,2, 0,0,0, 1,0,        1,0,0,0, 0,0,0,0, 13);
    add(1,0,0, 1,2,2, 0,0,0, 1,0,        0,0,0,0, 0,0,0,0, 2);
    add(1,0,0, 1,2,2, 0,0,0, 1,0,        0,0,1,0, 1,0,0,0, 2);
    // Reset during ISSUE of a port 1 request: no response, next tie goes to port 0.
    add(1,0,1, 0,0,0, 3,0,3, 1,1,        0,1,0,0, 0,0,0,0, 2);
    add(0,0,0, 0,0,0, 3,0,3, 1,1,        0,0,0,0, 0,0,0,0, 3);
    add(1,1,1, 4,4,11, 3,0,3, 1,1,       1,0,0,0, 0,0,0,0, 0);
    add(1,0,0, 4,4,11, 3,0,3, 1,1,       0,0,0,0, 0,0,0,0, 11);
    add(1,0,0, 4,4,11, 3,0,3, 1,1,       0,0,1,0, 1,0,0,0, 11);
    add(1,0,0, 4,4,11, 3,0,3, 1,1,       0,0,0,0, 0,0,0,0, 11);

    // Bring the DUT out of power-up with two reset edges.
    drive(0,0,0, 0,0,0, 0,0,0, 0,0);
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].c0,
            tbl[i].a1, tbl[i].b1, tbl[i].c1, tbl[i].rr0, tbl[i].rr1);
      @(negedge clk);
      chk($sformatf("row%0d rdy0", i), 32'(req0_ready), 32'(tbl[i].rdy0));
      chk($sformatf("row%0d rdy1", i), 32'(req1_ready), 32'(tbl[i].rdy1));
      chk($sformatf("row%0d rv0", i),  32'(resp0_valid), 32'(tbl[i].rv0));
      chk($sformatf("row%0d rv1", i),  32'(resp1_valid), 32'(tbl[i].rv1));
      chk($sformatf("row%0d s0", i),   32'(resp0_s), 32'(tbl[i].s0));
      chk($sformatf("row%0d s1", i),   32'(resp1_s), 32'(tbl[i].s1));
      chk($sformatf("row%0d e0", i),   32'(resp0_err), 32'(tbl[i].e0));
      chk($sformatf("row%0d e1", i),   32'(resp1_err), 32'(tbl[i].e1));
      chk($sformatf("row%0d alu_ctrl", i), 32'(alu_ctrl), 32'(tbl[i].ac));
      @(posedge clk);
      #1;
    end

    // Randomized traffic, including occasional resets and illegal opcodes.
    m_busy = 0; m_age = 0; m_owner = 0; m_last = 1; m_a = '0; m_b = '0; m_c = '0;
    for (int i = 0; i < 3000; i++) begin
      drive((i < 2) ? 1'b0 : ($urandom_range(0, 79) != 0),
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            W'($urandom), W'($urandom), OW'($urandom_range(0, 15)),
            W'($urandom), W'($urandom), OW'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      @(negedge clk);
      if (i >= 2) model_check();
      model_step();
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
